// File: rtl/attention_dot_sequencer_if.sv
// Stream bundle for the attention dot-product sequencer: the q/k byte input
// stream and the score output stream, each with valid/ready.
// The "slave" modport is the sequencer's view; "master" is the view of the
// logic feeding q/k bytes and draining scores.
interface attention_dot_sequencer_if;
    logic [7:0] qk_in;
    logic       qk_vld_in;
    logic       qk_rdy_out;
    logic [7:0] score_out;
    logic       score_vld_out;
    logic       score_rdy_in;

    modport slave (
        input  qk_in,
        input  qk_vld_in,
        input  score_rdy_in,
        output qk_rdy_out,
        output score_out,
        output score_vld_out
    );

    modport master (
        output qk_in,
        output qk_vld_in,
        output score_rdy_in,
        input  qk_rdy_out,
        input  score_out,
        input  score_vld_out
    );
endinterface

// File: rtl/attention_dot_sequencer.sv
// Attention dot-product sequencer: collects interleaved q/k bytes, accumulates
// VEC_LEN products, then presents one shifted, 8-bit-saturated score and holds
// it until the consumer takes it. The accumulator clears after each score.
module attention_dot_sequencer #(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned ACC_W   = 18,
    parameter int unsigned SHIFT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    attention_dot_sequencer_if.slave  bus,
    output logic                      busy_out,
    output logic [3:0]                pair_idx_out
);

    localparam int unsigned SumW = ACC_W + 1;

    // Elaboration-time parameter legality checks.
    if (VEC_LEN < 1 || VEC_LEN > 16) begin : g_bad_vec_len
        $error("attention_dot_sequencer: VEC_LEN must be in 1..16");
    end
    if (SHIFT >= ACC_W) begin : g_bad_shift
        $error("attention_dot_sequencer: SHIFT must be below ACC_W");
    end
    // Worst-case dot product must fit the accumulator without saturating.
    if (((64'(VEC_LEN) * 64'd65025) >> ACC_W) != 64'd0) begin : g_bad_acc_w
        $error("attention_dot_sequencer: ACC_W too narrow for VEC_LEN*255*255");
    end

    typedef enum logic [1:0] {
        StQ,
        StK,
        StOut
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         pair_idx_q, pair_idx_d;
    logic [7:0]         q_q, q_d;
    logic [7:0]         score_q, score_d;

    logic               qk_xfer;
    logic               score_xfer;
    logic [15:0]        product;
    logic [SumW-1:0]    sum_wide;
    logic [ACC_W-1:0]   acc_sat;
    logic [ACC_W-1:0]   acc_shifted;
    logic [7:0]         score_sat;

    // Datapath: 8x8 product, saturating accumulate, shift and clamp to 8 bits.
    always_comb begin
        product     = {8'd0, q_q} * {8'd0, bus.qk_in};
        sum_wide    = {1'b0, acc_q} + SumW'(product);
        acc_sat     = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        acc_shifted = acc_sat >> SHIFT;
        score_sat   = (acc_shifted > ACC_W'(255)) ? 8'hff : acc_shifted[7:0];
    end

    // Handshake outputs depend on state only, never on the incoming valid.
    always_comb begin
        bus.qk_rdy_out    = (state_q == StQ) || (state_q == StK);
        bus.score_vld_out = (state_q == StOut);
        bus.score_out     = score_q;
        busy_out          = (state_q != StQ) || (pair_idx_q != 4'd0);
        pair_idx_out      = pair_idx_q;
        qk_xfer           = bus.qk_vld_in && bus.qk_rdy_out;
        score_xfer        = bus.score_vld_out && bus.score_rdy_in;
    end

    // Next-state logic: q capture, k accumulate, score hand-off.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pair_idx_d = pair_idx_q;
        q_d        = q_q;
        score_d    = score_q;
        unique case (state_q)
            StQ: begin
                if (qk_xfer) begin
                    q_d     = bus.qk_in;
                    state_d = StK;
                end
            end
            StK: begin
                if (qk_xfer) begin
                    acc_d = acc_sat;
                    if (pair_idx_q == 4'(VEC_LEN - 1)) begin
                        score_d    = score_sat;
                        pair_idx_d = 4'd0;
                        state_d    = StOut;
                    end else begin
                        pair_idx_d = pair_idx_q + 4'd1;
                        state_d    = StQ;
                    end
                end
            end
            StOut: begin
                if (score_xfer) begin
                    acc_d   = '0;
                    state_d = StQ;
                end
            end
            default: state_d = StQ;
        endcase
    end

    // State registers with synchronous reset; reset drops partial and pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StQ;
            acc_q      <= '0;
            pair_idx_q <= 4'd0;
            q_q        <= 8'd0;
            score_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pair_idx_q <= pair_idx_d;
            q_q        <= q_d;
            score_q    <= score_d;
        end
    end

endmodule

// File: tb/tb_attention_dot_sequencer.sv
// Bench for attention_dot_sequencer. Two instances share one stimulus stream:
// one with SHIFT=8 and one with SHIFT=0, so both scaling cases are checked at
// once. A reference model turns accepted bytes into expected scores pushed on
// a queue; a monitor pops and compares whenever a score is taken.
module tb_attention_dot_sequencer;

    localparam int unsigned VL = 4;
    localparam int unsigned AW = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] qk;
    logic       qk_vld;
    logic       score_rdy;
    logic       busy8, busy0;
    logic [3:0] pidx8, pidx0;

    int checks = 0;
    int errors = 0;
    int n_exp  = 0;
    int n_got  = 0;

    typedef struct packed {
        logic [7:0] s8;
        logic [7:0] s0;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned model_bytes[$];
    exp_t        mon_e;

    attention_dot_sequencer_if if8 ();
    attention_dot_sequencer_if if0 ();

    assign if8.qk_in        = qk;
    assign if8.qk_vld_in    = qk_vld;
    assign if8.score_rdy_in = score_rdy;
    assign if0.qk_in        = qk;
    assign if0.qk_vld_in    = qk_vld;
    assign if0.score_rdy_in = score_rdy;

    attention_dot_sequencer #(.VEC_LEN(VL), .ACC_W(AW), .SHIFT(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .bus          (if8.slave),
        .busy_out     (busy8),
        .pair_idx_out (pidx8)
    );

    attention_dot_sequencer #(.VEC_LEN(VL), .ACC_W(AW), .SHIFT(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .bus          (if0.slave),
        .busy_out     (busy0),
        .pair_idx_out (pidx0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sat8(input longint x);
        return (x > 255) ? 8'd255 : 8'(x);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Reference model: a vector is complete after 2*VL bytes; score is the
    // plain dot product, capped to the accumulator range, shifted and clamped.
    function automatic void model_push_byte(input int unsigned b);
        longint sum;
        exp_t   e;
        model_bytes.push_back(b);
        if (model_bytes.size() == 2 * VL) begin
            sum = 0;
            for (int i = 0; i < int'(VL); i++)
                sum += longint'(model_bytes[2*i]) * longint'(model_bytes[2*i+1]);
            if (sum > (longint'(1) << AW) - 1) sum = (longint'(1) << AW) - 1;
            e.s8 = sat8(sum >> 8);
            e.s0 = sat8(sum);
            exp_q.push_back(e);
            n_exp++;
            model_bytes.delete();
        end
    endfunction

    // Offer one byte and hold it until accepted; returns 1 time unit after the
    // accepting edge. Ready depends only on state, so it is read between edges.
    task automatic send(input logic [7:0] b);
        int n;
        qk     = b;
        qk_vld = 1'b1;
        n      = 0;
        while (!if8.qk_rdy_out && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            fail("send_timeout");
            qk_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            qk_vld = 1'b0;
            model_push_byte(b);
        end
    endtask

    task automatic send_pair(input logic [7:0] q, input logic [7:0] k);
        send(q);
        send(k);
    endtask

    // Scoreboard monitor: a score is consumed when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && if8.score_vld_out && score_rdy) begin
            n_got++;
            if (exp_q.size() == 0) begin
                fail("unexpected_score");
            end else begin
                mon_e = exp_q.pop_front();
                check("score_shift8", if8.score_out, mon_e.s8);
                check("score_shift0", if0.score_out, mon_e.s0);
                check("score_vld_shift0", if0.score_vld_out, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit drv_done;
        int n;
        logic [7:0] held;

        rst       = 1'b1;
        qk        = 8'd0;
        qk_vld    = 1'b0;
        score_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_score_vld", if8.score_vld_out, 0);
        check("rst_score", if8.score_out, 0);
        check("rst_busy", busy8, 0);
        check("rst_pair_idx", pidx8, 0);
        check("rst_qk_rdy", if8.qk_rdy_out, 1);

        // 16*16 x4 back-to-back: acc=1024, score 4 (shift 8) / 255 (shift 0).
        score_rdy = 1'b1;
        send(8'd16);
        check("busy_after_q", busy8, 1);
        check("pair_idx_after_q", pidx8, 0);
        send(8'd16);
        check("pair_idx_after_k", pidx8, 1);
        for (int i = 1; i < int'(VL); i++) send_pair(8'd16, 8'd16);
        check("latency_vld_rise", if8.score_vld_out, 1);
        check("qk_rdy_in_out_state", if8.qk_rdy_out, 0);
        @(posedge clk);
        #1;
        check("vld_single_cycle", if8.score_vld_out, 0);
        check("back_to_q_rdy", if8.qk_rdy_out, 1);

        // 255*255 x4: 260100>>8 = 1016 clamps to 255.
        for (int i = 0; i < int'(VL); i++) send_pair(8'd255, 8'd255);

        // Small products, then a zero vector to show the accumulator cleared.
        send_pair(8'd1, 8'd2);
        send_pair(8'd3, 8'd4);
        send_pair(8'd5, 8'd6);
        send_pair(8'd7, 8'd8);
        for (int i = 0; i < int'(VL); i++) send_pair(8'd0, 8'd0);

        // Backpressure: score held for 10 cycles while new data is offered.
        @(posedge clk);
        #1;
        score_rdy = 1'b0;
        for (int i = 0; i < int'(VL); i++) send_pair(8'd20, 8'd30);
        qk     = 8'hAA;
        qk_vld = 1'b1;
        held   = if8.score_out;
        for (int i = 0; i < 10; i++) begin
            check("bp_qk_rdy_low", if8.qk_rdy_out, 0);
            check("bp_score_vld", if8.score_vld_out, 1);
            check("bp_score_stable", if8.score_out, held);
            if (exp_q.size() > 0) check("bp_score_value", if8.score_out, exp_q[0].s8);
            @(posedge clk);
            #1;
        end
        score_rdy = 1'b1;
        qk_vld    = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release_vld", if8.score_vld_out, 0);
        check("bp_release_rdy", if8.qk_rdy_out, 1);
        for (int i = 0; i < int'(VL); i++) send_pair(8'(i + 9), 8'(2 * i + 3));

        // Random gaps (one forced q/k gap) and random consumer backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 20; v++) begin
                    for (int j = 0; j < 2 * int'(VL); j++) begin
                        if ((v == 0 && j == 1) || $urandom_range(0, 2) == 0) begin
                            qk_vld = 1'b0;
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                        send(8'($urandom_range(0, 255)));
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #2;
                    score_rdy = 1'($urandom_range(0, 1));
                end
                score_rdy = 1'b1;
            end
        join

        // Drain pending scores before the reset test.
        n = 0;
        while ((exp_q.size() != 0 || if8.score_vld_out) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail("drain_random");

        // Reset after 5 accepted bytes discards the partial vector.
        for (int i = 0; i < 5; i++) send(8'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_bytes.delete();
        check("midrst_pair_idx", pidx8, 0);
        check("midrst_busy", busy8, 0);
        check("midrst_score_vld", if8.score_vld_out, 0);
        check("midrst_qk_rdy", if8.qk_rdy_out, 1);
        for (int i = 0; i < int'(VL); i++) send_pair(8'd2, 8'd3);

        n = 0;
        while ((exp_q.size() != 0 || if8.score_vld_out) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail("drain_final");
        check("scores_taken_vs_vectors", n_got, n_exp);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
